// File: rtl/rv32i_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// +-----------------------------------------------------------------------------+
// | rv32i_pkg : RV32I opcode constants and immediate format enumeration         |
// | Revision  : 1.0                                                             |
// +-----------------------------------------------------------------------------+
package rv32i_pkg;

    localparam logic [6:0] C_OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] C_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] C_OPC_JALR   = 7'b1100111;
    localparam logic [6:0] C_OPC_STORE  = 7'b0100011;
    localparam logic [6:0] C_OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] C_OPC_LUI    = 7'b0110111;
    localparam logic [6:0] C_OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] C_OPC_JAL    = 7'b1101111;
    localparam logic [6:0] C_OPC_OP     = 7'b0110011;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } imm_fmt_e;

    function automatic logic [31:0] sext12(input logic [11:0] v);
        return {{20{v[11]}}, v};
    endfunction

endpackage
`default_nettype wire

// File: rtl/imm_decode_comb.sv
`default_nettype none
`timescale 1ns/1ps
// +-----------------------------------------------------------------------------+
// | imm_decode_comb : purely combinational RV32I immediate/format decoder       |
// | Revision        : 1.0                                                       |
// +-----------------------------------------------------------------------------+
module imm_decode_comb
    import rv32i_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr_i,
    output logic [XLEN-1:0] imm_o,
    output imm_fmt_e        fmt_o,
    output logic            illegal_o
);

    logic [31:0] w_imm32;

    always_comb begin
        w_imm32   = '0;
        fmt_o     = FMT_R;
        illegal_o = 1'b0;
        case (instr_i[6:0])
            C_OPC_OP_IMM, C_OPC_LOAD, C_OPC_JALR: begin
                fmt_o   = FMT_I;
                w_imm32 = sext12(instr_i[31:20]);
            end
            C_OPC_STORE: begin
                fmt_o   = FMT_S;
                w_imm32 = sext12({instr_i[31:25], instr_i[11:7]});
            end
            C_OPC_BRANCH: begin
                fmt_o   = FMT_B;
                w_imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                           instr_i[30:25], instr_i[11:8], 1'b0};
            end
            C_OPC_LUI, C_OPC_AUIPC: begin
                fmt_o   = FMT_U;
                w_imm32 = {instr_i[31:12], 12'b0};
            end
            C_OPC_JAL: begin
                fmt_o   = FMT_J;
                w_imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                           instr_i[20], instr_i[30:21], 1'b0};
            end
            C_OPC_OP: begin
                fmt_o   = FMT_R;
            end
            default: begin
                illegal_o = 1'b1;
            end
        endcase
    end

    // All formats carry their sign in bit 31 once assembled, so widening is uniform.
    if (XLEN > 32) begin : g_sext_wide
        assign imm_o = {{(XLEN-32){w_imm32[31]}}, w_imm32};
    end else begin : g_sext_native
        assign imm_o = w_imm32[XLEN-1:0];
    end

endmodule
`default_nettype wire

// File: rtl/imm_decode_stage.sv
`default_nettype none
`timescale 1ns/1ps
// +-----------------------------------------------------------------------------+
// | imm_decode_stage : immediate decode with a DEPTH-entry valid/ready buffer   |
// | Option: define IMM_DECODE_STATS_EN to add the illegal_cnt counter output.   |
// | Revision         : 1.0                                                      |
// +-----------------------------------------------------------------------------+
module imm_decode_stage
    import rv32i_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal
`ifdef IMM_DECODE_STATS_EN
    ,
    output logic [15:0]     illegal_cnt
`endif
);

    localparam int              PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int              CNT_W   = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

    typedef struct packed {
        logic [XLEN-1:0] imm;
        imm_fmt_e        fmt;
        logic            illegal;
    } entry_t;

    logic [XLEN-1:0]  w_dec_imm;
    imm_fmt_e         w_dec_fmt;
    logic             w_dec_illegal;
    entry_t           w_dec;
    entry_t           w_head;
    logic             w_push;
    logic             w_pop;

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    imm_decode_comb #(
        .XLEN (XLEN)
    ) u_comb (
        .instr_i   (in_instr),
        .imm_o     (w_dec_imm),
        .fmt_o     (w_dec_fmt),
        .illegal_o (w_dec_illegal)
    );

    assign w_dec = '{imm: w_dec_imm, fmt: w_dec_fmt, illegal: w_dec_illegal};

    // in_ready depends only on occupancy, so a full buffer never passes through.
    assign in_ready  = (count_q < C_DEPTH);
    assign out_valid = (count_q != '0);
    assign w_push    = in_valid && in_ready && !flush;
    assign w_pop     = out_valid && out_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: outputs are masked whenever the buffer is empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= w_dec;
        end
    end

    assign w_head      = mem_q[rd_ptr_q];
    assign out_imm     = out_valid ? w_head.imm     : '0;
    assign out_fmt     = out_valid ? w_head.fmt     : FMT_R;
    assign out_illegal = out_valid ? w_head.illegal : 1'b0;

`ifdef IMM_DECODE_STATS_EN
    logic [15:0] illegal_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_cnt_q <= '0;
        end else if (w_push && w_dec.illegal && (illegal_cnt_q != 16'hFFFF)) begin
            illegal_cnt_q <= illegal_cnt_q + 16'd1;
        end
    end

    assign illegal_cnt = illegal_cnt_q;
`endif

endmodule
`default_nettype wire
